ibex_perf_counters: RTL and testbench

Machine performance-counter unit (mcycle, minstret, mhpmcounter3..N, mhpmevent, mcountinhibit). Owns all counter state. Sits directly upstream of the CSR read mux: it answers CSR accesses in the counter address range, and its read data, hit and illegal flags feed the CSR register file's `csr_rdata_int` / `illegal_csr` selection.

---
 rtl/ibex_pkg.sv | 42 ++++
 rtl/ibex_perf_counters_if.sv | 27 ++
 rtl/ibex_counter.sv | 42 ++++
 rtl/ibex_perf_counters.sv | 144 ++++++++++++++
 tb/tb_ibex_perf_counters.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the machine performance-counter unit.
//   csr_op_e         : CSR access operation (read / write / set / clear)
//   csr_num_e        : CSR addresses used by the counter block
//   CSR_MCOUNTINHIBIT_*_BIT : fixed inhibit bit positions for mcycle / minstret
//   HPM_EVENT_NUM    : width of the hpm event strobe bus
//   hpm_impl_mask()  : bit K set for each implemented hpm index K (3..3+N-1)
package ibex_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER31  = 12'hB1F,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F
    } csr_num_e;

    localparam int unsigned CSR_MCOUNTINHIBIT_CY_BIT = 0;
    localparam int unsigned CSR_MCOUNTINHIBIT_IR_BIT = 2;
    localparam int unsigned HPM_EVENT_NUM            = 16;

    function automatic logic [31:0] hpm_impl_mask(input int unsigned num);
        logic [31:0] m;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i >= 3) && (i < 3 + num);
        end
        return m;
    endfunction

endpackage

// File: rtl/ibex_perf_counters_if.sv
// CSR access channel between the CSR file and the performance-counter unit.
//   master : issues csr_req_i / csr_op_i / csr_addr_i / csr_wdata_i, receives the response
//   slave  : the counter unit; returns csr_rvalid_o / csr_hit_o / csr_rdata_o / csr_illegal_o
//            one cycle after the request
interface ibex_perf_counters_if;
    import ibex_pkg::*;

    logic        csr_req_i;
    csr_op_e     csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_rvalid_o;
    logic        csr_hit_o;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;

    modport master (
        output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
        input  csr_rvalid_o, csr_hit_o, csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
        output csr_rvalid_o, csr_hit_o, csr_rdata_o, csr_illegal_o
    );

endinterface

// File: rtl/ibex_counter.sv
// Single performance counter, 64-bit view with CounterWidth implemented bits.
//   clk, rst : clock, asynchronous active-high reset
//   inc_en   : add one this cycle (ignored when either half is written)
//   we_lo    : replace bits [31:0] with wdata
//   we_hi    : replace bits [63:32] with wdata
//   wdata    : write data
//   value    : current value; bits at or above CounterWidth are always 0
module ibex_counter #(
    parameter int unsigned CounterWidth = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    localparam logic [63:0] Mask = (CounterWidth >= 64) ? {64{1'b1}} :
                                   ((64'd1 << CounterWidth) - 64'd1);

    logic [63:0] counter_q, counter_d;

    always_comb begin
        counter_d = counter_q;
        if (we_lo) counter_d[31:0] = wdata;
        if (we_hi) counter_d[63:32] = wdata;
        // A write to either half drops the increment for the whole counter.
        if (!we_lo && !we_hi && inc_en) counter_d = counter_q + 64'd1;
        // Masking also gives the wrap to 0 at 2^CounterWidth.
        counter_d = counter_d & Mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) counter_q <= '0;
        else     counter_q <= counter_d;
    end

    assign value = counter_q;

endmodule

// File: rtl/ibex_perf_counters.sv
// Machine performance-counter unit: mcycle, minstret, mhpmcounter3..3+N-1, mhpmevent and
// mcountinhibit. Answers CSR accesses in the counter address range one cycle after the request.
//   clk, rst            : clock, asynchronous active-high reset
//   csr                 : CSR request/response channel (slave side)
//   instr_ret_i         : one instruction retired this cycle
//   hpm_event_i         : event strobes, selected per counter by mhpmeventK[15:0]
//   debug_mode_i, dcsr_stopcount_i : together they stop all counting
module ibex_perf_counters
    import ibex_pkg::*;
#(
    parameter int unsigned MHPMCounterNum   = 8,
    parameter int unsigned MHPMCounterWidth = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    ibex_perf_counters_if.slave      csr,
    input  logic                     instr_ret_i,
    input  logic [HPM_EVENT_NUM-1:0] hpm_event_i,
    input  logic                     debug_mode_i,
    input  logic                     dcsr_stopcount_i
);

    localparam logic [31:0] HpmMask     = hpm_impl_mask(MHPMCounterNum);
    localparam logic [31:0] InhibitMask = HpmMask | (32'd1 << CSR_MCOUNTINHIBIT_CY_BIT) |
                                          (32'd1 << CSR_MCOUNTINHIBIT_IR_BIT);
    localparam logic [11:0] CntLoBase   = CSR_MCYCLE;
    localparam logic [11:0] CntHiBase   = CSR_MCYCLEH;
    localparam logic [11:0] EvtBase     = CSR_MCOUNTINHIBIT;

    logic [63:0]              cnt_val [32];
    logic [HPM_EVENT_NUM-1:0] evt_val [32];
    logic [31:0]              inhibit_q;

    logic [4:0]  idx;
    logic        is_cnt_lo, is_cnt_hi, is_evt;
    logic        hit, illegal, csr_wr, stop;
    logic [31:0] rdata, wval;

    logic        rvalid_q, hit_q, illegal_q;
    logic [31:0] rdata_q;

    assign stop = debug_mode_i & dcsr_stopcount_i;

    // Address decode and pre-modification read value.
    always_comb begin
        idx       = csr.csr_addr_i[4:0];
        is_cnt_lo = csr.csr_addr_i[11:5] == CntLoBase[11:5];
        is_cnt_hi = csr.csr_addr_i[11:5] == CntHiBase[11:5];
        // 0x321/0x322 have no event register behind them.
        is_evt    = (csr.csr_addr_i[11:5] == EvtBase[11:5]) && (idx == 5'd0 || idx >= 5'd3);
        hit       = is_cnt_lo | is_cnt_hi | is_evt;
        illegal   = (is_cnt_lo | is_cnt_hi) && idx == 5'd1;
        rdata     = '0;
        if (is_cnt_lo)      rdata = cnt_val[idx][31:0];
        else if (is_cnt_hi) rdata = cnt_val[idx][63:32];
        else if (is_evt)    rdata = (idx == 5'd0) ? inhibit_q : {16'd0, evt_val[idx]};
        csr_wr    = csr.csr_req_i && (csr.csr_op_i != CSR_OP_READ) && !illegal;
    end

    always_comb begin
        unique case (csr.csr_op_i)
            CSR_OP_WRITE: wval = csr.csr_wdata_i;
            CSR_OP_SET:   wval = rdata | csr.csr_wdata_i;
            CSR_OP_CLEAR: wval = rdata & ~csr.csr_wdata_i;
            default:      wval = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit_q <= '0;
        end else if (csr_wr && is_evt && idx == 5'd0) begin
            inhibit_q <= wval & InhibitMask;
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_cnt
        if (k == 0 || k == 2 || HpmMask[k]) begin : g_impl
            logic inc, we_lo, we_hi;

            if (k == 0) begin : g_cycle
                assign inc = ~inhibit_q[k] & ~stop;
            end else if (k == 2) begin : g_instret
                assign inc = instr_ret_i & ~inhibit_q[k] & ~stop;
            end else begin : g_hpm
                assign inc = (|(hpm_event_i & evt_val[k])) & ~inhibit_q[k] & ~stop;
            end

            assign we_lo = csr_wr & is_cnt_lo & (idx == 5'(k));
            assign we_hi = csr_wr & is_cnt_hi & (idx == 5'(k));

            ibex_counter #(
                .CounterWidth((k < 3) ? 64 : MHPMCounterWidth)
            ) u_counter (
                .clk    (clk),
                .rst    (rst),
                .inc_en (inc),
                .we_lo  (we_lo),
                .we_hi  (we_hi),
                .wdata  (wval),
                .value  (cnt_val[k])
            );
        end else begin : g_none
            assign cnt_val[k] = '0;
        end

        if (HpmMask[k]) begin : g_evt
            logic [HPM_EVENT_NUM-1:0] evt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    evt_q <= '0;
                end else if (csr_wr && is_evt && idx == 5'(k)) begin
                    evt_q <= wval[HPM_EVENT_NUM-1:0];
                end
            end

            assign evt_val[k] = evt_q;
        end else begin : g_no_evt
            assign evt_val[k] = '0;
        end
    end

    // Response is registered so it reflects state before this cycle's write/increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q  <= 1'b0;
            hit_q     <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q  <= csr.csr_req_i;
            hit_q     <= csr.csr_req_i & hit;
            illegal_q <= csr.csr_req_i & illegal;
            rdata_q   <= csr.csr_req_i ? rdata : '0;
        end
    end

    assign csr.csr_rvalid_o  = rvalid_q;
    assign csr.csr_hit_o     = hit_q;
    assign csr.csr_illegal_o = illegal_q;
    assign csr.csr_rdata_o   = rdata_q;

endmodule

// File: tb/tb_ibex_perf_counters.sv
// Directed bench for ibex_perf_counters: each request pushes its expected response into a
// scoreboard queue; a monitor pops and compares whenever the DUT presents csr_rvalid_o.
module tb_ibex_perf_counters;
    import ibex_pkg::*;

    typedef struct {
        int          id;
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        hit;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        instr_ret;
    logic [15:0] hpm_event;
    logic        debug_mode;
    logic        stopcount;

    int   checks = 0;
    int   errors = 0;
    int   n_req  = 0;
    exp_t sb_q[$];
    exp_t e;

    ibex_perf_counters_if csr_if ();

    ibex_perf_counters #(
        .MHPMCounterNum   (8),
        .MHPMCounterWidth (40)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .csr              (csr_if),
        .instr_ret_i      (instr_ret),
        .hpm_event_i      (hpm_event),
        .debug_mode_i     (debug_mode),
        .dcsr_stopcount_i (stopcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (csr_if.csr_rvalid_o !== 1'b0 || csr_if.csr_hit_o !== 1'b0 ||
                csr_if.csr_illegal_o !== 1'b0 || csr_if.csr_rdata_o !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs: got rvalid=%b hit=%b ill=%b rdata=%h, want all 0",
                         csr_if.csr_rvalid_o, csr_if.csr_hit_o, csr_if.csr_illegal_o,
                         csr_if.csr_rdata_o);
            end
        end else if (csr_if.csr_rvalid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, want no response",
                         csr_if.csr_rdata_o);
            end else begin
                e = sb_q.pop_front();
                if (csr_if.csr_rdata_o !== e.rdata || csr_if.csr_hit_o !== e.hit ||
                    csr_if.csr_illegal_o !== e.ill) begin
                    errors++;
                    $display("FAIL req%0d_addr_%h: got rdata=%h hit=%b ill=%b, want rdata=%h hit=%b ill=%b",
                             e.id, e.addr, csr_if.csr_rdata_o, csr_if.csr_hit_o,
                             csr_if.csr_illegal_o, e.rdata, e.hit, e.ill);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the next one, so consecutive
    // calls produce back-to-back requests.
    task automatic access(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] erd, input logic ehit, input logic eill);
        csr_if.csr_req_i   = 1'b1;
        csr_if.csr_op_i    = op;
        csr_if.csr_addr_i  = addr;
        csr_if.csr_wdata_i = wdata;
        sb_q.push_back('{id: n_req, addr: addr, rdata: erd, hit: ehit, ill: eill});
        n_req++;
        @(posedge clk);
        #1;
        csr_if.csr_req_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] erd);
        access(CSR_OP_READ, addr, 32'd0, erd, 1'b1, 1'b0);
    endtask

    task automatic wr(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] epre);
        access(op, addr, wdata, epre, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst                = 1'b1;
        instr_ret          = 1'b0;
        hpm_event          = '0;
        debug_mode         = 1'b0;
        stopcount          = 1'b0;
        csr_if.csr_req_i   = 1'b0;
        csr_if.csr_op_i    = CSR_OP_READ;
        csr_if.csr_addr_i  = '0;
        csr_if.csr_wdata_i = '0;

        // Requests during reset are ignored.
        @(posedge clk);
        #1;
        csr_if.csr_req_i  = 1'b1;
        csr_if.csr_addr_i = 12'hB00;
        idle(1);
        csr_if.csr_req_i  = 1'b0;
        idle(2);
        rst = 1'b0;

        // mcycle free-runs from release.
        idle(10);
        rd(12'hB00, 32'd10);
        rd(12'hB80, 32'd0);

        // Carry from low into high half.
        wr(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF, 32'd12);
        idle(1);
        rd(12'hB80, 32'd1);
        rd(12'hB00, 32'd1);

        // Inhibit mcycle and minstret.
        wr(CSR_OP_WRITE, 12'h320, 32'h5, 32'd0);
        instr_ret = 1'b1;
        rd(12'h320, 32'h5);
        rd(12'hB00, 32'd3);
        idle(3);
        rd(12'hB00, 32'd3);
        rd(12'hB02, 32'd0);
        wr(CSR_OP_CLEAR, 12'h320, 32'h1, 32'h5);
        rd(12'h320, 32'h4);
        rd(12'hB00, 32'd4);
        rd(12'hB02, 32'd0);
        instr_ret = 1'b0;

        // hpm counter 3 selected on events 0 and 1.
        wr(CSR_OP_WRITE, 12'h323, 32'h3, 32'd0);
        hpm_event = 16'h0002;
        idle(5);
        hpm_event = 16'h0004;
        idle(2);
        hpm_event = 16'h0000;
        rd(12'hB03, 32'd5);
        rd(12'hB83, 32'd0);
        wr(CSR_OP_WRITE, 12'hB1F, 32'h1234, 32'd0);
        rd(12'hB1F, 32'd0);
        wr(CSR_OP_WRITE, 12'h33F, 32'hFFFF, 32'd0);
        rd(12'h33F, 32'd0);

        // Event register upper bits, time CSRs, out-of-range addresses.
        wr(CSR_OP_SET, 12'h323, 32'hFFFF_0000, 32'h3);
        rd(12'h323, 32'h3);
        access(CSR_OP_READ, 12'hB01, 32'd0, 32'd0, 1'b1, 1'b1);
        access(CSR_OP_WRITE, 12'hB81, 32'd5, 32'd0, 1'b1, 1'b1);
        access(CSR_OP_READ, 12'h321, 32'd0, 32'd0, 1'b0, 1'b0);
        access(CSR_OP_READ, 12'h300, 32'd0, 32'd0, 1'b0, 1'b0);

        // Write beats increment in the same cycle.
        wr(CSR_OP_CLEAR, 12'h320, 32'h4, 32'h4);
        instr_ret = 1'b1;
        wr(CSR_OP_WRITE, 12'hB02, 32'd100, 32'd0);
        rd(12'hB02, 32'd100);
        instr_ret = 1'b0;
        rd(12'hB02, 32'd101);

        // Debug stopcount freezes counting.
        debug_mode = 1'b1;
        stopcount  = 1'b1;
        instr_ret  = 1'b1;
        idle(3);
        rd(12'hB02, 32'd101);
        instr_ret  = 1'b0;
        debug_mode = 1'b0;
        stopcount  = 1'b0;

        // Half writes and hpm width limit.
        wr(CSR_OP_WRITE, 12'hB82, 32'hAB, 32'd0);
        rd(12'hB82, 32'hAB);
        rd(12'hB02, 32'd101);
        wr(CSR_OP_WRITE, 12'hB83, 32'hFFFF_FFFF, 32'd0);
        rd(12'hB83, 32'hFF);
        rd(12'hB03, 32'd5);
        wr(CSR_OP_WRITE, 12'h320, 32'hFFFF_FFFF, 32'd0);
        rd(12'h320, 32'h7FD);

        // Reset while a response is pending: the response is dropped.
        csr_if.csr_req_i  = 1'b1;
        csr_if.csr_op_i   = CSR_OP_READ;
        csr_if.csr_addr_i = 12'hB00;
        @(posedge clk);
        #2;
        rst = 1'b1;
        csr_if.csr_req_i = 1'b0;
        idle(3);
        rst = 1'b0;
        rd(12'hB00, 32'd0);
        rd(12'hB80, 32'd0);
        rd(12'hB02, 32'd0);
        rd(12'hB82, 32'd0);
        rd(12'hB03, 32'd0);
        rd(12'h320, 32'd0);
        rd(12'h323, 32'd0);

        idle(3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: got %0d outstanding, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
